// File: rtl/alu_result_stage_pkg.sv
// Shared definitions for the ALU result stage: datapath width, mode encodings
// and bit positions of the stored flag vector.
package alu_result_stage_pkg;

  localparam int unsigned ALU_WIDTH = 32;

  typedef enum logic [1:0] {
    ModeAdd = 2'b00,
    ModeSub = 2'b01,
    ModeSlt = 2'b11
  } alu_mode_e;

  // Flag vector layout {carry, overflow, zero}
  localparam int unsigned FLAG_ZERO  = 0;
  localparam int unsigned FLAG_OVF   = 1;
  localparam int unsigned FLAG_CARRY = 2;
  localparam int unsigned FLAG_W     = 3;

  // ctl1=1 with ctl0=0 never comes from upstream; it is folded into SLT.
  function automatic alu_mode_e decode_mode(input logic ctl0, input logic ctl1);
    if (ctl1) return ModeSlt;
    else if (ctl0) return ModeSub;
    else return ModeAdd;
  endfunction

endpackage

// File: rtl/alu_result_stage_flag_calc.sv
// Combinational zero and signed-overflow flags derived from the adder output
// and the operand sign bits.
module alu_flag_calc
  import alu_result_stage_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] sum,
  input  logic             a_msb,
  input  logic             b_msb,
  input  logic             ctl0,
  input  logic             ctl1,
  output logic             zero,
  output logic             overflow
);

  alu_mode_e mode;
  logic      sign_flip;

  assign mode      = decode_mode(ctl0, ctl1);
  assign zero      = ~|sum;
  assign sign_flip = sum[WIDTH-1] != a_msb;

  always_comb begin
    overflow = 1'b0;
    unique case (mode)
      ModeAdd: overflow = (a_msb == b_msb) & sign_flip;
      ModeSub: overflow = (a_msb != b_msb) & sign_flip;
      ModeSlt: overflow = 1'b0;
      default: overflow = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU output stage: 2-entry skid buffer with valid/ready handshake,
// stored flags per beat and a saturating overflow event counter.
module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter int unsigned WIDTH     = ALU_WIDTH,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     sum,
  input  logic                 cout_in,
  input  logic                 a_msb,
  input  logic                 b_msb,
  input  logic                 ctl0,
  input  logic                 ctl1,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic                 zero,
  output logic                 overflow,
  output logic                 carry,
  output logic [CNT_WIDTH-1:0] ovf_count,
  input  logic                 ovf_clear
);

  logic              in_zero, in_ovf;
  logic [FLAG_W-1:0] in_flags;

  alu_flag_calc #(
    .WIDTH (WIDTH)
  ) u_flag_calc (
    .sum      (sum),
    .a_msb    (a_msb),
    .b_msb    (b_msb),
    .ctl0     (ctl0),
    .ctl1     (ctl1),
    .zero     (in_zero),
    .overflow (in_ovf)
  );

  always_comb begin
    in_flags             = '0;
    in_flags[FLAG_ZERO]  = in_zero;
    in_flags[FLAG_OVF]   = in_ovf;
    in_flags[FLAG_CARRY] = cout_in;
  end

  logic              main_valid_q, main_valid_d;
  logic [WIDTH-1:0]  main_data_q, main_data_d;
  logic [FLAG_W-1:0] main_flags_q, main_flags_d;
  logic              skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0]  skid_data_q, skid_data_d;
  logic [FLAG_W-1:0] skid_flags_q, skid_flags_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic              push, pop;

  assign in_ready = ~skid_valid_q;
  assign push     = in_valid & in_ready;
  assign pop      = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_flags_d = main_flags_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_flags_d = skid_flags_q;
    if (skid_valid_q) begin
      // push cannot happen here since in_ready is low
      if (pop) begin
        main_data_d  = skid_data_q;
        main_flags_d = skid_flags_q;
        skid_valid_d = 1'b0;
      end
    end else if (push) begin
      if (!main_valid_q || pop) begin
        main_valid_d = 1'b1;
        main_data_d  = sum;
        main_flags_d = in_flags;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = sum;
        skid_flags_d = in_flags;
      end
    end else if (pop) begin
      main_valid_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (ovf_clear) begin
      cnt_d = '0;
    end else if (push && in_flags[FLAG_OVF] && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_flags_q <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_flags_q <= '0;
      cnt_q        <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_flags_q <= main_flags_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_flags_q <= skid_flags_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid = main_valid_q;
  assign result    = main_data_q;
  assign zero      = main_flags_q[FLAG_ZERO];
  assign overflow  = main_flags_q[FLAG_OVF];
  assign carry     = main_flags_q[FLAG_CARRY];
  assign ovf_count = cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage: reset, flags, skid
// buffering, counter saturation/clear and reset while full.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] sum;
  logic        cout_in, a_msb, b_msb, ctl0, ctl1;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero, overflow, carry;
  logic [15:0] ovf_count;
  logic        ovf_clear;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_cnt = 16'd0;

  always #5 clk = ~clk;

  alu_result_stage #(
    .WIDTH     (32),
    .CNT_WIDTH (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .cout_in   (cout_in),
    .a_msb     (a_msb),
    .b_msb     (b_msb),
    .ctl0      (ctl0),
    .ctl1      (ctl1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow),
    .carry     (carry),
    .ovf_count (ovf_count),
    .ovf_clear (ovf_clear)
  );

  task automatic set_beat(input logic [31:0] s, input logic c, input logic a, input logic b,
                          input logic c0, input logic c1);
    sum = s; cout_in = c; a_msb = a; b_msb = b; ctl0 = c0; ctl1 = c1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; ovf_clear = 1'b0;
    set_beat(32'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        failures++; $display("FAIL reset_out_valid cyc%0d got=%b exp=0", i, out_valid);
      end
      checks++;
      if (in_ready !== 1'b1) begin
        failures++; $display("FAIL reset_in_ready cyc%0d got=%b exp=1", i, in_ready);
      end
      checks++;
      if (ovf_count !== 16'd0) begin
        failures++; $display("FAIL reset_ovf_count cyc%0d got=%0d exp=0", i, ovf_count);
      end
    end
    reset = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_add_overflow();
    set_beat(32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    exp_cnt = 16'd1;
    checks++;
    if (out_valid !== 1'b1 || result !== 32'h8000_0000) begin
      failures++;
      $display("FAIL add_result got v=%b r=%h exp v=1 r=80000000", out_valid, result);
    end
    checks++;
    if ({overflow, zero, carry} !== 3'b100) begin
      failures++; $display("FAIL add_flags got ovf,z,c=%b%b%b exp=100", overflow, zero, carry);
    end
    checks++;
    if (ovf_count !== exp_cnt) begin
      failures++; $display("FAIL add_ovf_count got=%0d exp=%0d", ovf_count, exp_cnt);
    end
  endtask

  task automatic test_sub_zero();
    set_beat(32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== 32'h0) begin
      failures++; $display("FAIL sub_result got v=%b r=%h exp v=1 r=0", out_valid, result);
    end
    checks++;
    if ({overflow, zero, carry} !== 3'b011) begin
      failures++; $display("FAIL sub_flags got ovf,z,c=%b%b%b exp=011", overflow, zero, carry);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL drain_out_valid got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_flags();
    // SUB: negative minus positive giving positive -> overflow
    set_beat(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    exp_cnt = exp_cnt + 16'd1;
    checks++;
    if ({overflow, zero, carry} !== 3'b101) begin
      failures++; $display("FAIL sub_ovf_flags got=%b%b%b exp=101", overflow, zero, carry);
    end
    // SLT with the same sign pattern: overflow suppressed, result untouched
    set_beat(32'h0000_0001, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    checks++;
    if (result !== 32'h1 || {overflow, zero, carry} !== 3'b000) begin
      failures++;
      $display("FAIL slt_flags got r=%h f=%b%b%b exp r=1 f=000", result, overflow, zero, carry);
    end
    // ctl1=1, ctl0=0 behaves as SLT (ADD rule would flag this)
    set_beat(32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    checks++;
    if (result !== 32'h8000_0000 || overflow !== 1'b0) begin
      failures++; $display("FAIL slt_alias got r=%h ovf=%b exp r=80000000 ovf=0", result, overflow);
    end
    checks++;
    if (ovf_count !== exp_cnt) begin
      failures++; $display("FAIL flags_ovf_count got=%0d exp=%0d", ovf_count, exp_cnt);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] got[$];
    logic [31:0] exp_seq[3];
    logic        accepting;
    exp_seq[0] = 32'h1; exp_seq[1] = 32'h2; exp_seq[2] = 32'h3;
    out_ready = 1'b0;
    set_beat(32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    step();
    set_beat(32'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL skid_in_ready got=%b exp=0", in_ready);
    end
    set_beat(32'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== 32'h1) begin
      failures++;
      $display("FAIL hold got rdy=%b v=%b r=%h exp rdy=0 v=1 r=1", in_ready, out_valid, result);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (out_valid && out_ready) got.push_back(result);
      accepting = in_valid && in_ready;
      step();
      if (accepting) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    checks++;
    if (got.size() != 3) begin
      failures++; $display("FAIL order_count got=%0d exp=3", got.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= got.size()) begin
        failures++; $display("FAIL order_beat%0d got=missing exp=%h", i, exp_seq[i]);
      end else if (got[i] !== exp_seq[i]) begin
        failures++; $display("FAIL order_beat%0d got=%h exp=%h", i, got[i], exp_seq[i]);
      end
    end
    checks++;
    if (ovf_count !== exp_cnt) begin
      failures++; $display("FAIL b2b_ovf_count got=%0d exp=%0d", ovf_count, exp_cnt);
    end
  endtask

  task automatic test_saturation();
    ovf_clear = 1'b1;
    step();
    ovf_clear = 1'b0;
    checks++;
    if (ovf_count !== 16'd0) begin
      failures++; $display("FAIL clear got=%0d exp=0", ovf_count);
    end
    set_beat(32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 65536; i++) step();
    checks++;
    if (ovf_count !== 16'hFFFF) begin
      failures++; $display("FAIL saturate got=%h exp=ffff", ovf_count);
    end
    step();
    checks++;
    if (ovf_count !== 16'hFFFF) begin
      failures++; $display("FAIL saturate_hold got=%h exp=ffff", ovf_count);
    end
    ovf_clear = 1'b1;
    step();
    ovf_clear = 1'b0; in_valid = 1'b0;
    checks++;
    if (ovf_count !== 16'd0) begin
      failures++; $display("FAIL clear_wins got=%h exp=0", ovf_count);
    end
    checks++;
    if (out_valid !== 1'b1 || overflow !== 1'b1) begin
      failures++; $display("FAIL clear_beat got v=%b ovf=%b exp v=1 ovf=1", out_valid, overflow);
    end
    step();
  endtask

  task automatic test_reset_full();
    int seen;
    out_ready = 1'b0; in_valid = 1'b1;
    set_beat(32'hA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    set_beat(32'hB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      failures++; $display("FAIL full_before got rdy=%b v=%b exp rdy=0 v=1", in_ready, out_valid);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0) begin
      failures++;
      $display("FAIL reset_full got v=%b rdy=%b r=%h exp v=0 rdy=1 r=0", out_valid, in_ready,
               result);
    end
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) seen++;
      step();
    end
    checks++;
    if (seen != 0) begin
      failures++; $display("FAIL ghost_beats got=%0d exp=0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_zero();
    test_flags();
    test_back_to_back();
    test_saturation();
    test_reset_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
